// File: rtl/clk_enable_scheduler_pkg.sv
// Shared types and defaults for the clock-enable scheduler.
package clk_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } sched_state_t;

  localparam int N_CH_DEF  = 4;
  localparam int DIV_W_DEF = 16;

  // Width of a channel index; never narrower than one bit.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_enable_scheduler_if.sv
// Divisor configuration port: valid/ready write of one channel's divisor.
interface clk_enable_scheduler_if
  import clk_sched_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int DIV_W = DIV_W_DEF
) ();

  localparam int CH_W = ch_idx_w(N_CH);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_div,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_div,
    output cfg_ready
  );

endinterface

// File: rtl/clk_enable_scheduler_channel.sv
// One enable channel: active divisor, phase counter, shadow divisor and
// pending flag. The tick is decoded from registers only.
module clk_sched_channel
  import clk_sched_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,   // scheduler is in RUN
  input  logic             sync_i,  // realign, already qualified with RUN
  input  logic             wr_i,    // accepted config write to this channel
  input  logic [DIV_W-1:0] wdiv_i,
  output logic             tick_o,
  output logic             pend_o
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] sdiv_q, sdiv_d;
  logic             pend_q, pend_d;
  logic             wrap;

  // Last cycle of the current period; a zero divisor never wraps.
  assign wrap   = (div_q != '0) && (cnt_q == div_q - DIV_W'(1));
  assign tick_o = run_i && wrap;
  assign pend_o = pend_q;

  // Next-state: counting, shadow loads on wrap/sync, config capture.
  always_comb begin
    div_d  = div_q;
    cnt_d  = cnt_q;
    sdiv_d = sdiv_q;
    pend_d = pend_q;
    if (!run_i) begin
      // Outside RUN the phase is held at zero and writes take effect at once,
      // replacing anything that was still waiting in the shadow register.
      cnt_d = '0;
      if (wr_i) begin
        div_d  = wdiv_i;
        pend_d = 1'b0;
      end
    end else begin
      // Sync, a disabled channel and a normal wrap all restart the phase and
      // are the only moments a shadow divisor may become active, so the old
      // period is never truncated. The sync edge plays the role of the RUN
      // entry edge: counter at zero on the following cycle.
      if (sync_i || (div_q == '0) || wrap) begin
        cnt_d = '0;
        if (pend_q) begin
          div_d  = sdiv_q;
          pend_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
      // A write is only accepted while nothing is pending, so capturing it
      // after the load above keeps it queued for the next wrap.
      if (wr_i) begin
        sdiv_d = wdiv_i;
        pend_d = 1'b1;
      end
    end
  end

  // Channel state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q  <= '0;
      cnt_q  <= '0;
      sdiv_q <= '0;
      pend_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      sdiv_q <= sdiv_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/clk_enable_scheduler.sv
// Periodic clock-enable generator: run/stop FSM, config decode, ready mux
// and N_CH divider channels.
module clk_enable_scheduler
  import clk_sched_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  run_i,
  input  logic                  sync_i,
  clk_enable_scheduler_if.slave cfg,
  output logic [N_CH-1:0]       tick_o,
  output logic                  running_o
);

  localparam int CH_W    = ch_idx_w(N_CH);
  localparam int CH_SPAN = 1 << CH_W;

  sched_state_t       state_q;
  logic               running_q;
  logic               sync_run;
  logic               cfg_fire;
  logic [CH_SPAN-1:0] pend_vec;

  // Run/stop sequencer; dropping run_i wins over every other transition.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (run_i) state_q <= ARM;
        end
        ARM: begin
          if (run_i) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (!run_i) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign running_o = running_q;
  assign sync_run  = sync_i && running_q;

  // Ready depends only on the addressed channel's pending flag, never on
  // cfg_valid. Unused index slots read as not pending, so writes to them
  // are accepted and dropped.
  assign cfg.cfg_ready = !running_q || !pend_vec[cfg.cfg_ch];
  assign cfg_fire      = cfg.cfg_valid && cfg.cfg_ready;

  generate
    for (genvar gi = 0; gi < CH_SPAN; gi++) begin : g_ch
      if (gi < N_CH) begin : g_live
        clk_sched_channel #(
          .DIV_W (DIV_W)
        ) u_ch (
          .clk    (CLK),
          .rst_n  (RST_N),
          .run_i  (running_q),
          .sync_i (sync_run),
          .wr_i   (cfg_fire && (cfg.cfg_ch == CH_W'(gi))),
          .wdiv_i (cfg.cfg_div),
          .tick_o (tick_o[gi]),
          .pend_o (pend_vec[gi])
        );
      end else begin : g_pad
        assign pend_vec[gi] = 1'b0;
      end
    end
  endgenerate

endmodule
